// File: rtl/mul_red_pipe.sv
// Three-stage modular multiply-reduce pipeline for the shared Kyber/Dilithium NTT datapath.
// Per beat: K mode gives two 12-bit products mod KQ per lane, D mode one 23-bit product mod DQ.
module mul_red_pipe #(
    parameter int LANES = 1,
    parameter int TAG_W = 4,
    parameter int KQ    = 3329,
    parameter int DQ    = 8380417
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic                  in_prev_a,
    input  logic                  in_prev_w,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [24*LANES-1:0]   in_a,
    input  logic [24*LANES-1:0]   in_w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [TAG_W-1:0]      out_tag,
    output logic [24*LANES-1:0]   out_res
);

    // Barrett constants: floor(2^k / Q) with k = product width, so the quotient
    // estimate is low by at most one and a single final subtract suffices.
    localparam logic [23:0] KM   = 24'((64'd1 << 24) / 64'(KQ));
    localparam logic [45:0] DM   = 46'((64'd1 << 46) / 64'(DQ));
    localparam logic [12:0] KQ13 = 13'(KQ);
    localparam logic [23:0] DQ24 = 24'(DQ);

    function automatic logic [12:0] k_red(input logic [23:0] x);
        logic [23:0] q;
        q = 24'((48'(x) * 48'(KM)) >> 24);
        return 13'(x - 24'(48'(q) * 48'(KQ)));
    endfunction

    function automatic logic [11:0] k_fix(input logic [12:0] r);
        return (r >= KQ13) ? 12'(r - KQ13) : r[11:0];
    endfunction

    function automatic logic [23:0] d_red(input logic [45:0] x);
        logic [45:0] q;
        q = 46'((92'(x) * 92'(DM)) >> 46);
        return 24'(x - 46'(92'(q) * 92'(DQ)));
    endfunction

    function automatic logic [22:0] d_fix(input logic [23:0] r);
        return (r >= DQ24) ? 23'(r - DQ24) : r[22:0];
    endfunction

    logic             w_en;
    logic             w_acc;

    logic             r1_v;
    logic             r1_mode;
    logic [TAG_W-1:0] r1_tag;
    logic             r2_v;
    logic             r2_mode;
    logic [TAG_W-1:0] r2_tag;
    logic             r3_v;
    logic             r3_mode;
    logic [TAG_W-1:0] r3_tag;

    assign w_en      = out_ready | ~r3_v;
    assign w_acc     = in_valid & w_en;
    assign in_ready  = w_en;
    assign out_valid = r3_v;
    assign out_mode  = r3_mode;
    assign out_tag   = r3_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_v    <= 1'b0;
            r1_mode <= 1'b0;
            r1_tag  <= '0;
            r2_v    <= 1'b0;
            r2_mode <= 1'b0;
            r2_tag  <= '0;
            r3_v    <= 1'b0;
            r3_mode <= 1'b0;
            r3_tag  <= '0;
        end else if (w_en) begin
            r1_v    <= in_valid;
            r1_mode <= in_mode;
            r1_tag  <= in_tag;
            r2_v    <= r1_v;
            r2_mode <= r1_mode;
            r2_tag  <= r1_tag;
            r3_v    <= r2_v;
            r3_mode <= r2_mode;
            r3_tag  <= r2_tag;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [23:0] r_prev_a;
        logic [23:0] r_prev_w;
        logic [23:0] w_a;
        logic [23:0] w_w;
        logic [23:0] r1_pkh;
        logic [23:0] r1_pkl;
        logic [45:0] r1_pd;
        logic [12:0] r2_rkh;
        logic [12:0] r2_rkl;
        logic [23:0] r2_rd;
        logic [23:0] r3_res;
        logic [23:0] w_res;

        assign w_a = in_prev_a ? r_prev_a : in_a[24*g +: 24];
        assign w_w = in_prev_w ? r_prev_w : in_w[24*g +: 24];

        assign w_res = r2_mode ? {1'b0, d_fix(r2_rd)}
                               : {k_fix(r2_rkh), k_fix(r2_rkl)};

        assign out_res[24*g +: 24] = r3_res;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prev_a <= '0;
                r_prev_w <= '0;
                r1_pkh   <= '0;
                r1_pkl   <= '0;
                r1_pd    <= '0;
                r2_rkh   <= '0;
                r2_rkl   <= '0;
                r2_rd    <= '0;
                r3_res   <= '0;
            end else begin
                // Raw operands are remembered even when the beat itself reused them.
                if (w_acc) begin
                    r_prev_a <= in_a[24*g +: 24];
                    r_prev_w <= in_w[24*g +: 24];
                end
                if (w_en) begin
                    r1_pkh <= 24'(w_a[23:12]) * 24'(w_w[23:12]);
                    r1_pkl <= 24'(w_a[11:0]) * 24'(w_w[11:0]);
                    r1_pd  <= 46'(w_a[22:0]) * 46'(w_w[22:0]);
                    r2_rkh <= k_red(r1_pkh);
                    r2_rkl <= k_red(r1_pkl);
                    r2_rd  <= d_red(r1_pd);
                    r3_res <= w_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_red_pipe.sv
// Directed bench for mul_red_pipe with hand-computed expected results.
module tb_mul_red_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic        in_prev_a;
    logic        in_prev_w;
    logic [3:0]  in_tag;
    logic [23:0] in_a;
    logic [23:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [3:0]  out_tag;
    logic [23:0] out_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_red_pipe #(
        .LANES(1),
        .TAG_W(4),
        .KQ(3329),
        .DQ(8380417)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mode(in_mode),
        .in_prev_a(in_prev_a),
        .in_prev_w(in_prev_w),
        .in_tag(in_tag),
        .in_a(in_a),
        .in_w(in_w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode(out_mode),
        .out_tag(out_tag),
        .out_res(out_res)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic pa,
                         input logic pw, input logic [3:0] t,
                         input logic [23:0] a, input logic [23:0] w);
        in_valid  = v;
        in_mode   = m;
        in_prev_a = pa;
        in_prev_w = pw;
        in_tag    = t;
        in_a      = a;
        in_w      = w;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [23:0] res,
                           input logic [3:0] t, input logic m);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".res"}, 32'(out_res), 32'(res));
        chk({nm, ".tag"}, 32'(out_tag), 32'(t));
        chk({nm, ".mode"}, 32'(out_mode), 32'(m));
    endtask

    logic [23:0] t5a [6] = '{24'h001002, 24'd1000, 24'h064064,
                             24'd8380417, 24'hD01D00, 24'h800003};
    logic [23:0] t5w [6] = '{24'h003004, 24'd1000, 24'h064064,
                             24'd5, 24'h007D00, 24'd3};
    logic [23:0] t5e [6] = '{24'h003008, 24'd1000000, 24'h00D00D,
                             24'd0, 24'h000001, 24'd9};
    logic        t5m [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [23:0] q_res  [$];
    logic [3:0]  q_tag  [$];
    logic        q_mode [$];

    initial begin
        int i;
        int nout;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hold_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.res", 32'(out_res), 32'd0);
        chk("rst.tag", 32'(out_tag), 32'd0);
        chk("rst.mode", 32'(out_mode), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        step();

        // prev_a on the first beat after reset reads zero
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 24'h007007, 24'h001001);
        step();
        idle();
        step();
        step();
        chk_out("prev0", 24'h000000, 4'd9, 1'b0);

        // K mode, latency exactly 3
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 24'hD00002, 24'hD00680);
        step();
        idle();
        step();
        chk("t1.early", 32'(out_valid), 32'd0);
        step();
        chk_out("t1", 24'h001D00, 4'd5, 1'b0);

        // D mode back-to-back
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 24'd8380416, 24'd8380416);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 24'd4194304, 24'd2);
        step();
        idle();
        step();
        chk_out("t2a", 24'd1, 4'd1, 1'b1);
        step();
        chk_out("t2b", 24'd8191, 4'd2, 1'b1);

        // unreduced 12-bit K inputs
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 24'hFFFFFF, 24'hFFF000);
        step();
        idle();
        step();
        step();
        chk_out("t3", 24'h354000, 4'd3, 1'b0);

        // operand reuse; idle beat with prev flags must not disturb state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 24'h00A014, 24'h001001);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 24'h000000, 24'h003003);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 24'h063063, 24'h099099);
        step();
        chk_out("t4a", 24'h00A014, 4'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 24'h002002, 24'h000000);
        step();
        chk_out("t4b", 24'h01E03C, 4'd2, 1'b0);
        idle();
        step();
        chk("t4.bubble", 32'(out_valid), 32'd0);
        step();
        chk_out("t4c", 24'h006006, 4'd3, 1'b0);
        step();

        // mixed stream with a 4-cycle downstream stall
        i    = 0;
        nout = 0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            out_ready = !(c >= 4 && c < 8);
            if (i < 6)
                drive(1'b1, t5m[i], 1'b0, 1'b0, 4'(i + 1), t5a[i], t5w[i]);
            else
                idle();
            #1;
            if (!out_ready) begin
                chk("bp.in_ready", 32'(in_ready), 32'd0);
                chk("bp.hold_valid", 32'(out_valid), 32'd1);
                chk("bp.hold_res", 32'(out_res), 32'(q_res[0]));
                chk("bp.hold_tag", 32'(out_tag), 32'(q_tag[0]));
            end
            if (out_valid && out_ready) begin
                if (q_res.size() == 0) begin
                    chk("bp.extra", 32'(out_valid), 32'd0);
                end else begin
                    chk("bp.res", 32'(out_res), 32'(q_res[0]));
                    chk("bp.tag", 32'(out_tag), 32'(q_tag[0]));
                    chk("bp.mode", 32'(out_mode), 32'(q_mode[0]));
                    void'(q_res.pop_front());
                    void'(q_tag.pop_front());
                    void'(q_mode.pop_front());
                    nout++;
                end
            end
            if (in_valid && in_ready) begin
                q_res.push_back(t5e[i]);
                q_tag.push_back(4'(i + 1));
                q_mode.push_back(t5m[i]);
                i++;
            end
            step();
        end
        out_ready = 1'b1;
        idle();
        chk("bp.accepted", 32'(i), 32'd6);
        chk("bp.delivered", 32'(nout), 32'd6);
        step();
        chk("bp.drain", 32'(out_valid), 32'd0);

        // async reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'(10 + k), 24'h005005, 24'h001001);
            step();
        end
        idle();
        chk_out("rst.pre", 24'h005005, 4'd10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.async_valid", 32'(out_valid), 32'd0);
        chk("rst.async_res", 32'(out_res), 32'd0);
        chk("rst.async_tag", 32'(out_tag), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rst.no_stale", 32'(out_valid), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 24'h009009, 24'h005005);
        step();
        idle();
        step();
        step();
        chk_out("rst.prev", 24'h000000, 4'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
